// File: rtl/cache_access_arbiter_if.sv
// Requester and cache-side handshake bundle for the cache access arbiter.
// The master modport is the requester/cache side; the slave modport is the arbiter.
interface cache_access_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [2*NUM_REQ-1:0]      req_type;
  logic [ADDR_W*NUM_REQ-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cache_valid;
  logic [1:0]                Access_type;
  logic [ADDR_W-1:0]         Hex_address;
  logic                      cache_done;

  modport master (
    output req_valid, req_type, req_addr, cache_done,
    input  req_ready, cache_valid, Access_type, Hex_address
  );

  modport slave (
    input  req_valid, req_type, req_addr, cache_done,
    output req_ready, cache_valid, Access_type, Hex_address
  );
endinterface

// File: rtl/cache_access_arbiter.sv
// Round-robin arbiter that keeps one access outstanding to a shared cache model,
// filtering illegal request types and abandoning accesses that never complete.
module cache_access_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  cache_access_arbiter_if.slave      bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       illegal_type,
  output logic                       timeout_err,
  output logic [31:0]                issue_count
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

  state_t            state_reg, state_next;
  logic [PW-1:0]     rr_reg, rr_next;
  logic [PW-1:0]     grant_reg, grant_next;
  logic [PW-1:0]     winner;
  logic              any_valid;
  logic [1:0]        type_reg, type_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              timeout_reg, timeout_next;
  logic [31:0]       count_reg, count_next;
  logic [CW-1:0]     wait_reg, wait_next, wait_inc;

  logic [1:0]        type_arr [NUM_REQ];
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign type_arr[gi] = bus.req_type[2*gi +: 2];
      assign addr_arr[gi] = bus.req_addr[ADDR_W*gi +: ADDR_W];
    end
  endgenerate

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    int cand;
    any_valid = 1'b0;
    winner    = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_valid && bus.req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = PW'(cand);
      end
    end
  end

  assign wait_inc = wait_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      rr_reg      <= '0;
      grant_reg   <= '0;
      type_reg    <= '0;
      addr_reg    <= '0;
      timeout_reg <= 1'b0;
      count_reg   <= '0;
      wait_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      rr_reg      <= rr_next;
      grant_reg   <= grant_next;
      type_reg    <= type_next;
      addr_reg    <= addr_next;
      timeout_reg <= timeout_next;
      count_reg   <= count_next;
      wait_reg    <= wait_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rr_next      = rr_reg;
    grant_next   = grant_reg;
    type_next    = type_reg;
    addr_next    = addr_reg;
    timeout_next = timeout_reg;
    count_next   = count_reg;
    wait_next    = wait_reg;
    unique case (state_reg)
      IDLE: begin
        if (any_valid) begin
          type_next  = type_arr[winner];
          addr_next  = addr_arr[winner];
          grant_next = winner;
          rr_next    = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          state_next = (type_arr[winner] == 2'd3) ? ERR : ISSUE;
        end
      end
      ISSUE: begin
        if (count_reg != '1) count_next = count_reg + 32'd1;
        wait_next  = '0;
        state_next = bus.cache_done ? IDLE : WAIT;
      end
      WAIT: begin
        // A completion arriving on the last allowed cycle wins over the abort.
        if (bus.cache_done) begin
          state_next = IDLE;
        end else begin
          wait_next = wait_inc;
          if (wait_inc == CW'(TIMEOUT - 1)) begin
            timeout_next = 1'b1;
            state_next   = IDLE;
          end
        end
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is withheld during reset so nothing is accepted that the FSM then loses.
  always_comb begin
    bus.req_ready = '0;
    if (state_reg == IDLE && any_valid && !rst) bus.req_ready = NUM_REQ'(1) << winner;
    bus.cache_valid = (state_reg == ISSUE);
    illegal_type    = (state_reg == ERR);
    bus.Access_type = type_reg;
    bus.Hex_address = addr_reg;
    grant_id        = grant_reg;
    timeout_err     = timeout_reg;
    issue_count     = count_reg;
  end
endmodule

// File: tb/tb_cache_access_arbiter.sv
// Directed bench for cache_access_arbiter: reset, single access, fairness,
// illegal filtering, timeout, reset during WAIT and done-versus-timeout precedence.
module tb_cache_access_arbiter;
  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  grant_id;
  logic        illegal_type;
  logic        timeout_err;
  logic [31:0] issue_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] fa [3];

  cache_access_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus ();

  cache_access_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .grant_id     (grant_id),
    .illegal_type (illegal_type),
    .timeout_err  (timeout_err),
    .issue_count  (issue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.cache_done = 1'b0;
    edge_();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid  = '0;
    bus.req_type   = '0;
    bus.req_addr   = '0;
    bus.cache_done = 1'b0;
    fa[0] = 32'h0000_A000;
    fa[1] = 32'h0000_B000;
    fa[2] = 32'h0000_C000;

    // Reset state and idle period
    edge_();
    do_reset();
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_cvalid", bus.cache_valid, 0);
    chk("rst_atype", bus.Access_type, 0);
    chk("rst_addr", bus.Hex_address, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_illegal", illegal_type, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_count", issue_count, 0);
    for (int i = 0; i < 10; i++) begin
      edge_();
      #1;
      chk("idle_ready", bus.req_ready, 0);
      chk("idle_cvalid", bus.cache_valid, 0);
    end
    chk("idle_count", issue_count, 0);

    // Single read from requester 0, done three cycles after issue
    edge_();
    bus.req_valid = 3'b001;
    bus.req_type  = 6'b00_00_00;
    bus.req_addr  = {32'h0, 32'h0, 32'h0000_1040};
    #1;
    chk("rd_ready", bus.req_ready, 3'b001);
    edge_();
    bus.req_valid = '0;
    #1;
    chk("rd_ready_low", bus.req_ready, 0);
    chk("rd_cvalid", bus.cache_valid, 1);
    chk("rd_atype", bus.Access_type, 0);
    chk("rd_addr", bus.Hex_address, 32'h0000_1040);
    chk("rd_grant", grant_id, 0);
    edge_();
    #1;
    chk("rd_wait_cvalid", bus.cache_valid, 0);
    chk("rd_count", issue_count, 1);
    edge_();
    edge_();
    bus.cache_done = 1'b1;
    bus.req_valid  = 3'b001;
    bus.req_addr   = {32'h0, 32'h0, 32'h0000_3000};
    #1;
    chk("rd_no_early_grant", bus.req_ready, 0);
    edge_();
    bus.cache_done = 1'b0;
    #1;
    chk("rd_regrant", bus.req_ready, 3'b001);
    chk("rd_count_hold", issue_count, 1);
    do_reset();

    // Fairness: all valid, done returned during ISSUE
    bus.req_type = 6'b00_00_00;
    bus.req_addr = {fa[2], fa[1], fa[0]};
    for (int g = 0; g < 6; g++) begin
      bus.req_valid  = 3'b111;
      bus.cache_done = 1'b0;
      #1;
      chk("rr_ready", bus.req_ready, 64'(3'b001 << (g % 3)));
      edge_();
      bus.cache_done = 1'b1;
      #1;
      chk("rr_cvalid", bus.cache_valid, 1);
      chk("rr_grant", grant_id, 64'(g % 3));
      chk("rr_addr", bus.Hex_address, fa[g % 3]);
      edge_();
    end
    bus.cache_done = 1'b0;
    #1;
    chk("rr_count", issue_count, 6);
    do_reset();

    // Illegal type from requester 1
    bus.req_valid = 3'b010;
    bus.req_type  = 6'b00_11_00;
    bus.req_addr  = {32'h0, 32'hDEAD_BEEF, 32'h0};
    #1;
    chk("ill_ready", bus.req_ready, 3'b010);
    edge_();
    bus.req_valid = '0;
    #1;
    chk("ill_pulse", illegal_type, 1);
    chk("ill_cvalid", bus.cache_valid, 0);
    chk("ill_atype", bus.Access_type, 3);
    chk("ill_addr", bus.Hex_address, 32'hDEAD_BEEF);
    chk("ill_grant", grant_id, 1);
    chk("ill_count", issue_count, 0);
    edge_();
    bus.req_valid = 3'b111;
    bus.req_type  = 6'b01_00_00;
    bus.req_addr  = {32'h0000_00C0, 32'h0000_00B0, 32'h0000_00A0};
    #1;
    chk("ill_pulse_end", illegal_type, 0);
    chk("ill_rr_ptr2", bus.req_ready, 3'b100);

    // Write from requester 2 never completes
    edge_();
    bus.req_valid = 3'b001;
    #1;
    chk("to_cvalid", bus.cache_valid, 1);
    chk("to_atype", bus.Access_type, 1);
    chk("to_grant", grant_id, 2);
    for (int k = 1; k <= 15; k++) begin
      edge_();
      #1;
      if (k == 7) begin
        chk("to_addr_held", bus.Hex_address, 32'h0000_00C0);
        chk("to_wait_cvalid", bus.cache_valid, 0);
      end
    end
    chk("to_not_yet", timeout_err, 0);
    chk("to_busy_ready", bus.req_ready, 0);
    edge_();
    #1;
    chk("to_err", timeout_err, 1);
    chk("to_idle_ready", bus.req_ready, 3'b001);
    edge_();
    bus.req_valid  = '0;
    bus.cache_done = 1'b1;
    #1;
    chk("to_next_cvalid", bus.cache_valid, 1);
    chk("to_next_addr", bus.Hex_address, 32'h0000_00A0);
    edge_();
    bus.cache_done = 1'b0;

    // Reset during WAIT with requester 2 pending
    bus.req_valid = 3'b001;
    bus.req_type  = 6'b00_00_01;
    bus.req_addr  = {32'h0000_00C0, 32'h0000_00B0, 32'h0000_5000};
    #1;
    chk("to_sticky", timeout_err, 1);
    chk("to_count", issue_count, 2);
    chk("wr_ready", bus.req_ready, 3'b001);
    edge_();
    bus.req_valid = '0;
    edge_();
    rst = 1'b1;
    bus.req_valid = 3'b100;
    #1;
    chk("rstw_ready_in_rst", bus.req_ready, 0);
    edge_();
    rst = 1'b0;
    #1;
    chk("rstw_cvalid", bus.cache_valid, 0);
    chk("rstw_atype", bus.Access_type, 0);
    chk("rstw_addr", bus.Hex_address, 0);
    chk("rstw_grant", grant_id, 0);
    chk("rstw_timeout", timeout_err, 0);
    chk("rstw_count", issue_count, 0);
    chk("rstw_req2", bus.req_ready, 3'b100);
    bus.req_valid = 3'b101;
    #1;
    chk("rstw_rr0", bus.req_ready, 3'b001);
    bus.req_valid = '0;

    // Done arriving on the last allowed WAIT cycle beats the timeout
    edge_();
    bus.req_valid = 3'b001;
    bus.req_type  = '0;
    bus.req_addr  = {32'h0, 32'h0, 32'h0000_7000};
    #1;
    chk("pr_ready", bus.req_ready, 3'b001);
    edge_();
    bus.req_valid = '0;
    for (int k = 1; k <= 15; k++) begin
      edge_();
      if (k == 15) bus.cache_done = 1'b1;
    end
    #1;
    chk("pr_busy_ready", bus.req_ready, 0);
    edge_();
    bus.cache_done = 1'b0;
    bus.req_valid  = 3'b010;
    #1;
    chk("pr_no_err", timeout_err, 0);
    chk("pr_idle_ready", bus.req_ready, 3'b010);
    chk("pr_count", issue_count, 1);
    bus.req_valid = '0;
    edge_();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cache_access_arbiter.md
Name: cache_access_arbiter

Overview:
- Shares one cache simulation instance between NUM_REQ requesters (CPU read/write ports, snoop-invalidate port).
- Sequences exactly one outstanding cache access at a time.
- Sits between trace/CPU front ends and the cache, driving its Access_type/Hex_address inputs with round-robin fairness, illegal-type filtering and a completion timeout.

Parameters:
- NUM_REQ, 3, number of requesters (2 to 8).
- ADDR_W, 32, address width.
- TIMEOUT, 16, maximum WAIT cycles before abort (≥2).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_type  in  2*NUM_REQ  per-requester type, slice i = [2i+1:2i]; 0=read, 1=write, 2=invalidate, 3=illegal.
- req_addr  in  ADDR_W*NUM_REQ  per-requester address, slice i = [ADDR_W*(i+1)-1:ADDR_W*i].
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational.
- cache_valid  out  1  one-cycle issue strobe to cache.
- Access_type  out  2  registered type to cache.
- Hex_address  out  ADDR_W  registered address to cache.
- cache_done  in  1  cache completion pulse.
- grant_id  out  $clog2(NUM_REQ)  index of last granted requester.
- illegal_type  out  1  one-cycle pulse, illegal request consumed.
- timeout_err  out  1  sticky, cleared only by rst.
- issue_count  out  32  number of issued cache accesses, saturating.

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - req_ready = 0, cache_valid = 0, Access_type = 0, Hex_address = 0.
  - grant_id = 0, illegal_type = 0, timeout_err = 0, issue_count = 0, wait counter = 0.
- States: IDLE, ISSUE, WAIT, ERR.
- IDLE:
  - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - If any valid: req_ready[winner] = 1 in the same cycle (transfer occurs, since valid is high). Register type/addr into Access_type/Hex_address, grant_id = winner, rr_ptr = (winner+1) mod NUM_REQ.
  - Next state: ERR if type == 3, else ISSUE.
  - If no valid: all req_ready = 0, stay IDLE, rr_ptr unchanged.
- req_ready is 0 in every state other than IDLE. Requesters hold valid/type/addr stable until ready.
- ISSUE:
  - cache_valid = 1 for exactly this cycle.
  - issue_count++, saturating at 2^32-1.
  - Wait counter cleared to 0.
  - If cache_done = 1 this cycle, next state IDLE; else WAIT.
- WAIT:
  - cache_valid = 0; Access_type/Hex_address held.
  - If cache_done: next state IDLE.
  - Else counter++; when counter reaches TIMEOUT-1 without done: timeout_err <= 1, next state IDLE (access abandoned).
  - cache_done in the cycle the counter hits TIMEOUT-1 takes precedence: no error.
- ERR:
  - illegal_type = 1 for this cycle only, no cache_valid, next state IDLE.
- cache_done while in IDLE or ERR is ignored.
- Latency:
  - Minimum grant-to-grant spacing is 2 cycles (done during ISSUE).
  - Illegal requests also cost 2 cycles.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0,…; no requester waits more than NUM_REQ grants.
- rst asserted in any state returns to IDLE on the next edge. An in-flight access is dropped (no done wait); counters and the sticky error are cleared.
- Access_type/Hex_address change only on an IDLE grant or reset.

Test Plan:
- Reset then all req_valid = 0 for 10 cycles -> req_ready = 0, cache_valid never high, issue_count = 0.
- Req0 read of 0x0000_1040, cache_done pulsed 3 cycles after cache_valid -> req_ready[0] for 1 cycle; next cycle cache_valid = 1, Access_type = 0, Hex_address = 0x0000_1040; next grant no earlier than the cycle after done; issue_count = 1.
- All 3 requesters valid continuously, done returned in the ISSUE cycle -> grant_id sequence 0,1,2,0,1,2 with a grant every 2 cycles; issue_count = 6 after 12 cycles.
- Req1 type = 3 at 0xDEAD_BEEF -> req_ready[1] pulses; the following cycle illegal_type = 1 and cache_valid = 0; rr_ptr advances to 2.
- Write issued, cache_done never returned, TIMEOUT = 16 -> timeout_err rises 16 cycles after cache_valid, state returns to IDLE and accepts the next request; timeout_err stays 1 until rst.
- rst asserted during WAIT -> next cycle all outputs at reset values; a pending req2 is granted first after release only if req0 and req1 are idle (rr_ptr = 0).
